// File: rtl/ball_motion_ctrl.sv
// -----------------------------------------------------------------------------
// ball_motion_ctrl
//
// Moves a ball centre once per video frame. A frame tick is taken from the
// falling edge of the VGA vertical sync. On each tick (while enabled) the
// FSM steps X, then Y, then commits the result to the outputs. Velocities
// bounce off the visible area, inset by BALL_SIZE. A CPU on an Avalon-style
// write port sets velocities and control, and can load absolute positions.
//
// Parameters:
//   BALL_SIZE : ball radius in pixels, inset used for edge clamping
//   X_MAX     : rightmost visible pixel column
//   Y_MAX     : bottom visible pixel row
//
// Ports:
//   clk        : system clock, same domain as the VGA counters
//   reset      : asynchronous, active-high reset
//   chipselect : slave select
//   write      : write strobe
//   address    : register index
//                  0 dx (signed), 1 dy (signed),
//                  2 ctrl (bit0 enable, bit1 clear overrun),
//                  3 X[7:0] staging, 4 X[10:8] and load,
//                  5 Y[7:0] staging, 6 Y[9:8] and load, 7 unused
//   writedata  : write data
//   vga_vs     : active-low vertical sync
//   ball_x     : committed ball X centre
//   ball_y     : committed ball Y centre
//   pos_valid  : one-cycle strobe when ball_x/ball_y are updated
//   overrun    : sticky, set when a frame tick arrives while busy
//
// Build option:
//   BALL_MOTION_GRAVITY_EN : when defined, dy is incremented by one
//   (saturating at +15) at the start of every Y step.
// -----------------------------------------------------------------------------
module ball_motion_ctrl #(
   parameter int BALL_SIZE = 30,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic [2:0]  address,
   input  logic [7:0]  writedata,
   input  logic        vga_vs,
   output logic [10:0] ball_x,
   output logic [9:0]  ball_y,
   output logic        pos_valid,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

   localparam logic signed [12:0] POS_LO = 13'(BALL_SIZE);
   localparam logic signed [12:0] X_HI   = 13'(X_MAX - BALL_SIZE);
   localparam logic signed [12:0] Y_HI   = 13'(Y_MAX - BALL_SIZE);

   state_t             state_reg;
   logic               vs_reg;
   logic               enable_reg;
   logic [10:0]        x_reg;
   logic [9:0]         y_reg;
   logic signed [7:0]  dx_reg;
   logic signed [7:0]  dy_reg;
   logic [7:0]         x_stage_reg;
   logic [7:0]         y_stage_reg;

   logic               wr;
   logic               load_x;
   logic               load_y;
   logic               frame_tick;
   logic signed [7:0]  dy_eff;
   logic signed [12:0] nx;
   logic signed [12:0] ny;
   logic [10:0]        x_calc;
   logic [9:0]         y_calc;
   logic signed [7:0]  dx_calc;
   logic signed [7:0]  dy_calc;
   logic               unused_bits;

   // -128 has no positive counterpart in 8 bits, so it bounces back as +127.
   function automatic logic signed [7:0] negate_sat(input logic signed [7:0] d);
      return (d == 8'sh80) ? 8'sd127 : -d;
   endfunction

   assign wr         = chipselect & write;
   assign load_x     = wr && (address == 3'd4);
   assign load_y     = wr && (address == 3'd6);
   assign frame_tick = vs_reg & ~vga_vs;

   always_comb begin
`ifdef BALL_MOTION_GRAVITY_EN
      dy_eff = (dy_reg >= 8'sd15) ? dy_reg : dy_reg + 8'sd1;
`else
      dy_eff = dy_reg;
`endif
      nx      = $signed({2'b00, x_reg}) + $signed({{5{dx_reg[7]}}, dx_reg});
      ny      = $signed({3'b000, y_reg}) + $signed({{5{dy_eff[7]}}, dy_eff});
      x_calc  = nx[10:0];
      dx_calc = dx_reg;
      if (nx < POS_LO) begin
         x_calc  = POS_LO[10:0];
         dx_calc = negate_sat(dx_reg);
      end else if (nx > X_HI) begin
         x_calc  = X_HI[10:0];
         dx_calc = negate_sat(dx_reg);
      end
      y_calc  = ny[9:0];
      dy_calc = dy_eff;
      if (ny < POS_LO) begin
         y_calc  = POS_LO[9:0];
         dy_calc = negate_sat(dy_eff);
      end else if (ny > Y_HI) begin
         y_calc  = Y_HI[9:0];
         dy_calc = negate_sat(dy_eff);
      end
   end

   // Upper sum bits only matter for the range compares above.
   assign unused_bits = ^{nx[12:11], ny[12:10]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         vs_reg      <= 1'b1;
         enable_reg  <= 1'b0;
         x_reg       <= 11'd400;
         y_reg       <= 10'd300;
         dx_reg      <= 8'sd1;
         dy_reg      <= 8'sd1;
         x_stage_reg <= 8'd0;
         y_stage_reg <= 8'd0;
         ball_x      <= 11'd400;
         ball_y      <= 10'd300;
         pos_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         vs_reg    <= vga_vs;
         pos_valid <= 1'b0;

         // Clear first so a tick dropped in the same cycle still flags.
         if (wr && (address == 3'd2) && writedata[1])
            overrun <= 1'b0;

         if (load_x || load_y) begin
            // CPU load aborts any step in progress; a coincident tick is
            // silently discarded.
            state_reg <= IDLE;
            pos_valid <= 1'b1;
            if (load_x) begin
               x_reg  <= {writedata[2:0], x_stage_reg};
               ball_x <= {writedata[2:0], x_stage_reg};
               ball_y <= y_reg;
            end else begin
               y_reg  <= {writedata[1:0], y_stage_reg};
               ball_y <= {writedata[1:0], y_stage_reg};
               ball_x <= x_reg;
            end
         end else begin
            if (frame_tick && (state_reg != IDLE))
               overrun <= 1'b1;
            case (state_reg)
               IDLE: begin
                  if (frame_tick && enable_reg)
                     state_reg <= CALC_X;
               end
               CALC_X: begin
                  x_reg     <= x_calc;
                  dx_reg    <= dx_calc;
                  state_reg <= CALC_Y;
               end
               CALC_Y: begin
                  // Outputs are registered on entry to COMMIT so the new
                  // position and strobe are both visible during COMMIT.
                  y_reg     <= y_calc;
                  dy_reg    <= dy_calc;
                  ball_x    <= x_reg;
                  ball_y    <= y_calc;
                  pos_valid <= 1'b1;
                  state_reg <= COMMIT;
               end
               default: state_reg <= IDLE;
            endcase
         end

         // Register writes come last so a CPU velocity write wins over a
         // bounce update landing in the same cycle.
         if (wr) begin
            case (address)
               3'd0:    dx_reg      <= writedata;
               3'd1:    dy_reg      <= writedata;
               3'd2:    enable_reg  <= writedata[0];
               3'd3:    x_stage_reg <= writedata;
               3'd5:    y_stage_reg <= writedata;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

   localparam int BS   = 30;
   localparam int XMAX = 639;
   localparam int YMAX = 479;
`ifdef BALL_MOTION_GRAVITY_EN
   localparam bit GRAV = 1'b1;
`else
   localparam bit GRAV = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic [2:0]  address = 3'd0;
   logic [7:0]  writedata = 8'd0;
   logic        vga_vs = 1'b1;
   logic [10:0] ball_x;
   logic [9:0]  ball_y;
   logic        pos_valid;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_x, m_y, m_dx, m_dy;

   ball_motion_ctrl #(.BALL_SIZE(BS), .X_MAX(XMAX), .Y_MAX(YMAX)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .vga_vs(vga_vs),
      .ball_x(ball_x), .ball_y(ball_y), .pos_valid(pos_valid), .overrun(overrun)
   );

   always #10 clk = ~clk;

   // One axis step: optional gravity, move, clamp and bounce.
   task automatic model_axis(inout int p, inout int d, input int hi, input bit grav);
      int n;
      if (grav && d < 15) d = d + 1;
      n = p + d;
      if (n < BS || n > hi - BS) begin
         p = (n < BS) ? BS : hi - BS;
         d = (d == -128) ? 127 : -d;
      end else begin
         p = n;
      end
   endtask

   task automatic model_frame();
      model_axis(m_x, m_dx, XMAX, 1'b0);
      model_axis(m_y, m_dy, YMAX, GRAV);
   endtask

   task automatic model_reset();
      m_x = 400; m_y = 300; m_dx = 1; m_dy = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      vga_vs = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      $display("wr addr=%0d data=0x%02h", a, d);
      if (a == 3'd0) m_dx = int'($signed(d));
      if (a == 3'd1) m_dy = int'($signed(d));
   endtask

   // Stage low byte, then load with the high bits; checks the load strobe.
   task automatic load_pos(input bit is_y, input int v);
      logic [10:0] vv;
      vv = v[10:0];
      cpu_wr(is_y ? 3'd5 : 3'd3, vv[7:0]);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1;
      address   = is_y ? 3'd6 : 3'd4;
      writedata = is_y ? {6'd0, vv[9:8]} : {5'd0, vv[10:8]};
      if (is_y) m_y = v; else m_x = v;
      @(posedge clk); #1;
      checks++;
      if (pos_valid !== 1'b1 || ball_x !== 11'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL load: pv=%0b x=%0d y=%0d required pv=1 x=%0d y=%0d",
                  pos_valid, ball_x, ball_y, m_x, m_y);
      end
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      $display("load %s=%0d", is_y ? "y" : "x", v);
   endtask

   // One enabled frame: checks latency, outputs and strobe width.
   task automatic run_frame();
      model_frame();
      @(negedge clk);
      vga_vs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (pos_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_early: pos_valid=%0b required 0", pos_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (pos_valid !== 1'b1 || ball_x !== 11'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL frame: pv=%0b x=%0d y=%0d required pv=1 x=%0d y=%0d",
                  pos_valid, ball_x, ball_y, m_x, m_y);
      end
      @(negedge clk);
      vga_vs = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pos_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_width: pos_valid=%0b required 0", pos_valid);
      end
      $display("frame x=%0d y=%0d dx=%0d dy=%0d", ball_x, ball_y, m_dx, m_dy);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (ball_x !== 11'd400 || ball_y !== 10'd300 || pos_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset: x=%0d y=%0d pv=%0b ov=%0b required 400 300 0 0",
                  ball_x, ball_y, pos_valid, overrun);
      end
      $display("reset x=%0d y=%0d", ball_x, ball_y);
   endtask

   task automatic test_enable_off();
      @(negedge clk);
      vga_vs = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pos_valid !== 1'b0 || ball_x !== 11'd400) begin
            errors++;
            $display("FAIL enable_off: pv=%0b x=%0d required pv=0 x=400", pos_valid, ball_x);
         end
      end
      @(negedge clk);
      vga_vs = 1'b1;
      $display("tick with enable=0 ignored");
   endtask

   task automatic test_reset_velocity();
      cpu_wr(3'd2, 8'h01);
      run_frame();
      checks++;
      if (ball_x !== 11'd401 || ball_y !== 10'd301) begin
         errors++;
         $display("FAIL reset_velocity: x=%0d y=%0d required 401 301", ball_x, ball_y);
      end
   endtask

   task automatic test_basic();
      do_reset();
      cpu_wr(3'd2, 8'h01);
      cpu_wr(3'd0, 8'd3);
      cpu_wr(3'd1, 8'hFE);
      run_frame();
      checks++;
      if (ball_x !== 11'd403 || ball_y !== 10'd298) begin
         errors++;
         $display("FAIL basic: x=%0d y=%0d required 403 298", ball_x, ball_y);
      end
   endtask

   task automatic test_clamp_right();
      load_pos(1'b0, 607);
      cpu_wr(3'd0, 8'd5);
      run_frame();
      checks++;
      if (ball_x !== 11'd609) begin
         errors++;
         $display("FAIL clamp_right: x=%0d required 609", ball_x);
      end
      run_frame();
      checks++;
      if (ball_x !== 11'd604) begin
         errors++;
         $display("FAIL bounce_right: x=%0d required 604", ball_x);
      end
   endtask

   task automatic test_neg_saturate();
      load_pos(1'b0, 100);
      cpu_wr(3'd0, 8'h80);
      run_frame();
      checks++;
      if (ball_x !== 11'd30) begin
         errors++;
         $display("FAIL neg_sat_clamp: x=%0d required 30", ball_x);
      end
      run_frame();
      checks++;
      if (ball_x !== 11'd157) begin
         errors++;
         $display("FAIL neg_sat_dx: x=%0d required 157", ball_x);
      end
   endtask

   task automatic test_overrun();
      model_frame();
      @(negedge clk); vga_vs = 1'b0;   // tick, FSM leaves IDLE
      @(negedge clk); vga_vs = 1'b1;   // CALC_X
      @(negedge clk); vga_vs = 1'b0;   // second tick lands in CALC_Y
      @(posedge clk); #1;
      checks++;
      if (pos_valid !== 1'b1 || overrun !== 1'b1 || ball_x !== 11'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL overrun_set: pv=%0b ov=%0b x=%0d y=%0d required 1 1 %0d %0d",
                  pos_valid, overrun, ball_x, ball_y, m_x, m_y);
      end
      @(negedge clk); vga_vs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pos_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold: pv=%0b ov=%0b required 0 1", pos_valid, overrun);
         end
      end
      cpu_wr(3'd2, 8'h03);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: ov=%0b required 0", overrun);
      end
      $display("overrun set and cleared");
   endtask

   task automatic test_load_abort();
      logic [10:0] v;
      // Load during CALC_X aborts the step.
      v = 11'd250;
      cpu_wr(3'd3, v[7:0]);
      @(negedge clk); vga_vs = 1'b0;
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = {5'd0, v[10:8]};
      m_x = 250;
      @(posedge clk); #1;
      checks++;
      if (pos_valid !== 1'b1 || ball_x !== 11'd250 || ball_y !== 10'(m_y) || overrun !== 1'b0) begin
         errors++;
         $display("FAIL load_abort: pv=%0b x=%0d y=%0d ov=%0b required 1 250 %0d 0",
                  pos_valid, ball_x, ball_y, overrun, m_y);
      end
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; vga_vs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_abort_extra: pos_valid=%0b required 0", pos_valid);
         end
      end
      // Load coincident with a tick in IDLE: tick dropped, no overrun.
      v = 11'd320;
      cpu_wr(3'd3, v[7:0]);
      @(negedge clk);
      vga_vs = 1'b0;
      chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = {5'd0, v[10:8]};
      m_x = 320;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pos_valid !== 1'b0 || overrun !== 1'b0 || ball_x !== 11'd320) begin
            errors++;
            $display("FAIL load_tick: pv=%0b ov=%0b x=%0d required 0 0 320",
                     pos_valid, overrun, ball_x);
         end
      end
      @(negedge clk); vga_vs = 1'b1;
      run_frame();
      $display("load abort checks done");
   endtask

   task automatic test_reset_mid();
      @(negedge clk); vga_vs = 1'b0;
      @(negedge clk); reset = 1'b1;    // during CALC_X
      @(negedge clk); reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pos_valid !== 1'b0 || ball_x !== 11'd400 || ball_y !== 10'd300) begin
            errors++;
            $display("FAIL reset_mid: pv=%0b x=%0d y=%0d required 0 400 300",
                     pos_valid, ball_x, ball_y);
         end
      end
      @(negedge clk); vga_vs = 1'b1;
      $display("reset mid-calculation discarded");
   endtask

   task automatic test_random();
      cpu_wr(3'd2, 8'h01);
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 7))
            0: cpu_wr(3'd0, 8'($urandom_range(0, 255)));
            1: cpu_wr(3'd1, 8'($urandom_range(0, 255)));
            2: load_pos(1'b0, int'($urandom_range(0, 700)));
            3: load_pos(1'b1, int'($urandom_range(0, 520)));
            default: run_frame();
         endcase
      end
   endtask

   task automatic test_gravity();
`ifdef BALL_MOTION_GRAVITY_EN
      do_reset();
      cpu_wr(3'd2, 8'h01);
      cpu_wr(3'd1, 8'd0);
      run_frame();
      checks++;
      if (ball_y !== 10'd301) begin
         errors++;
         $display("FAIL gravity1: y=%0d required 301", ball_y);
      end
      run_frame();
      checks++;
      if (ball_y !== 10'd303) begin
         errors++;
         $display("FAIL gravity2: y=%0d required 303", ball_y);
      end
      run_frame();
      checks++;
      if (ball_y !== 10'd306) begin
         errors++;
         $display("FAIL gravity3: y=%0d required 306", ball_y);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_enable_off();
      test_reset_velocity();
      test_basic();
      test_clamp_right();
      test_neg_saturate();
      test_overrun();
      test_load_abort();
      test_reset_mid();
      test_random();
      test_gravity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
